cacheline_burst_adaptor: RTL



---
 rtl/cacheline_burst_adaptor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cacheline_burst_adaptor.sv
// Whole-line cache fill/writeback requests to fixed-length memory bursts, low beat first.
// Define ADAPTOR_TIMEOUT_EN to abort stalled bursts after `timeout` idle beat cycles (err_o).
//
//   state | meaning
//   IDLE  | waiting for read_i/write_i; latches aligned address and victim line
//   RD    | read_o held, beats from burst_i assembled into line_o
//   WR    | write_o held, burst_o driven from the buffered line
//   DONE  | one-cycle resp_o (and err_o on abort) to the cache
module cacheline_burst_adaptor #(
  parameter int s_offset    = 5,
  parameter int burst_width = 64,
  parameter int timeout     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          read_i,
  input  logic                          write_i,
  input  logic [31:0]                   address_i,
  input  logic [8*(2**s_offset)-1:0]    line_i,
  output logic [8*(2**s_offset)-1:0]    line_o,
  output logic                          resp_o,
  output logic                          err_o,
  input  logic [burst_width-1:0]        burst_i,
  output logic [burst_width-1:0]        burst_o,
  output logic [31:0]                   address_o,
  output logic                          read_o,
  output logic                          write_o,
  input  logic                          resp_i
);

  localparam int s_line    = 8 * (2 ** s_offset);
  localparam int num_beats = s_line / burst_width;
  localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state, state_next;
  logic [cnt_w-1:0]    count;
  logic [s_line-1:0]   wbuf;
  logic                abort;

  // Offset bits are dropped by line alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[s_offset-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    case (state)
      IDLE: begin
        if (write_i)     state_next = WR;
        else if (read_i) state_next = RD;
      end
      RD: begin
        read_o = 1'b1;
        if (abort || (resp_i && count == last_beat)) state_next = DONE;
      end
      WR: begin
        write_o = 1'b1;
        if (abort || (resp_i && count == last_beat)) state_next = DONE;
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    burst_o = '0;
    if (state == WR) burst_o = wbuf[count*burst_width +: burst_width];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      address_o <= '0;
      wbuf      <= '0;
      line_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
            count     <= '0;
          end
          if (write_i) wbuf <= line_i;
        end
        RD: begin
          if (resp_i) begin
            line_o[count*burst_width +: burst_width] <= burst_i;
            count <= count + 1'b1;
          end
        end
        WR: begin
          if (resp_i) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ADAPTOR_TIMEOUT_EN
  localparam int to_w = $clog2(timeout + 1);

  logic [to_w-1:0] to_cnt;
  logic            err_q;

  // Abort fires on the cycle the wait counter would reach the limit.
  assign abort = (state == RD || state == WR) && !resp_i
                 && (to_cnt == to_w'(timeout - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == RD || state == WR) begin
        if (resp_i) to_cnt <= '0;
        else        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
      err_q <= abort;
    end
  end

  assign err_o = err_q;
`else
  localparam int unused_timeout = timeout;

  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

endmodule
